// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states, legal lane masks, error data.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    localparam logic [31:0] RSP_DATA_ERR = 32'h0;

    function automatic logic be_legal(input logic [3:0] be);
        logic ok;
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: ok = 1'b1;
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with per-byte write enables: writes land on the rising edge, reads are combinational.
// Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [3:0]       wr_be,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [0:DEPTH_WORDS-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, response WAIT_CYCLES+1 edges after the accepting cycle.
// Response held until rsp_ready; optional lane-mask legality check under DMEM_BE_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [3:0]        req_be,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               ready_q;
    logic               cap_we;
    logic [3:0]         cap_be;
    logic [ADDR_W-1:0]  cap_addr;
    logic [31:0]        cap_wdata;

    logic               accept;
    logic               do_access;
    logic               acc_we;
    logic [3:0]         acc_be;
    logic [ADDR_W-1:0]  acc_addr;
    logic [31:0]        acc_wdata;
    logic               oob;
    logic               be_err;
    logic               acc_err;
    logic [3:0]         wr_be;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        rd_data;

    assign accept = req_valid && ready_q && (state == IDLE);

    always_comb begin
        state_nxt = state;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                        do_access = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                    do_access = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Zero-wait accesses use the live request; otherwise the captured copy.
    assign acc_we    = (state == IDLE) ? req_we    : cap_we;
    assign acc_be    = (state == IDLE) ? req_be    : cap_be;
    assign acc_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : cap_wdata;

    assign oob = (acc_addr >> (IDX_W + 2)) != '0;

`ifdef DMEM_BE_CHECK_EN
    assign be_err = (acc_be != 4'b0000) && !be_legal(acc_be);
`else
    assign be_err = 1'b0;
`endif

    assign acc_err = oob || be_err;
    assign wr_be   = (do_access && acc_we && !acc_err) ? acc_be : 4'b0000;
    assign idx     = acc_addr[IDX_W+1:2];

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_be   (wr_be),
        .wr_idx  (idx),
        .wr_data (acc_wdata),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ready_q   <= 1'b0;
            cap_we    <= 1'b0;
            cap_be    <= 4'b0000;
            cap_addr  <= '0;
            cap_wdata <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == IDLE);
            if (accept) begin
                cap_we    <= req_we;
                cap_be    <= req_be;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cnt       <= CNT_W'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (do_access) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || acc_we) ? RSP_DATA_ERR : rd_data;
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = (state == RESP);

endmodule
